// File: rtl/adc_serial_emulator_pkg.sv
// -----------------------------------------------------------------------------
// adc_emu_pkg
// Shared definitions for the serial ADC emulator: FSM state encoding, default
// frame geometry and the width of the completed-frame counter.
// -----------------------------------------------------------------------------
package adc_emu_pkg;

    // Frame state: waiting for cs_n, shifting the word out, or padding with
    // zeros after the last data bit until cs_n rises.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TRAIL = 2'd2
    } emu_state_e;

    localparam int DEF_LEAD_ZEROS = 3;
    localparam int DEF_DATA_BITS  = 12;
    localparam int FRAME_COUNT_W  = 16;

endpackage

// File: rtl/adc_serial_emulator_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Optional N-stage synchronizer followed by a single edge-detect register.
// All flops reset to 1 (the idle level of sclk and cs_n), so no spurious edge
// appears when reset is released with the line idle.
//
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw input line
//   level      : synchronized level
//   rise, fall : combinational one-cycle edge pulses (valid in the cycle the
//                synchronized level differs from the edge-detect register)
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_s;
    logic prev_r;

    generate
        if (STAGES == 0) begin : g_bypass
            // Same clock domain as the master: no synchronizer delay.
            assign sync_s = din;
        end else begin : g_sync
            logic [STAGES-1:0] chain_r;

            // Synchronizer chain, idle-high after reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_r <= {STAGES{1'b1}};
                end else begin
                    chain_r[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        chain_r[i] <= chain_r[i-1];
                    end
                end
            end

            assign sync_s = chain_r[STAGES-1];
        end
    endgenerate

    // Edge-detect register holding the previous synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= sync_s;
        end
    end

    assign level = sync_s;
    assign rise  = ~prev_r & sync_s;
    assign fall  = prev_r & ~sync_s;

endmodule

// File: rtl/adc_serial_emulator.sv
// -----------------------------------------------------------------------------
// adc_serial_emulator
// Behavioural-but-synthesizable model of a serial ADC slave. Each frame opened
// by cs_n falling shifts out LEAD_ZEROS zeros then a DATA_BITS sample, MSB
// first, one bit per sclk falling edge; zeros follow once the word is spent.
//
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   sclk, cs_n          : serial clock (idles high) and frame select from master
//   sdata, sdata_oe     : serial data and its pad output enable
//   sample_data/valid   : host sample; sample_ready pulses when it is taken
//   pattern_mode        : transmit the internal ramp instead of host samples
//   frame_done          : pulse when a frame ends after its last data bit
//   short_frame         : pulse when cs_n rises before the last data bit
//   frame_count         : number of completed frames (wrapping)
// -----------------------------------------------------------------------------
module adc_serial_emulator
    import adc_emu_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
    parameter int DATA_BITS   = DEF_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk,
    input  logic                     cs_n,
    output logic                     sdata,
    output logic                     sdata_oe,
    input  logic [DATA_BITS-1:0]     sample_data,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic                     pattern_mode,
    output logic                     frame_done,
    output logic                     short_frame,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int WORD_BITS = LEAD_ZEROS + DATA_BITS;
    localparam int IDX_W     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BITS - 1);

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sclk_act_s;
    logic unused_s;

    emu_state_e               state_r, state_s;
    logic [IDX_W-1:0]         bit_idx_r, bit_idx_s;
    logic [WORD_BITS-1:0]     shift_r, shift_s;
    logic [WORD_BITS-1:0]     word_s;
    logic [DATA_BITS-1:0]     sel_s;
    logic                     sdata_r, sdata_s;
    logic                     sdata_oe_r, sdata_oe_s;
    logic                     ready_r, ready_s;
    logic                     done_r, done_s;
    logic                     short_r, short_s;
    logic [FRAME_COUNT_W-1:0] count_r, count_s;
    logic [DATA_BITS-1:0]     ramp_r, ramp_s;
    logic [DATA_BITS-1:0]     last_r, last_s;
    logic                     last_bit_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (cs_level_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    // sclk edges only matter while the frame select is low; sclk rising edges
    // never change sdata.
    assign sclk_act_s = sclk_fall_s & ~cs_level_s;
    assign unused_s   = sclk_level_s ^ sclk_rise_s;

    // The last data bit is on the line once the index reaches the final slot.
    assign last_bit_s = (state_r == ST_SHIFT) && (bit_idx_r == LAST_IDX);

    // Next-state and datapath decode; cs_n rising has priority over all else.
    always_comb begin
        state_s    = state_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        sdata_s    = sdata_r;
        sdata_oe_s = sdata_oe_r;
        ready_s    = 1'b0;
        done_s     = 1'b0;
        short_s    = 1'b0;
        count_s    = count_r;
        ramp_s     = ramp_r;
        last_s     = last_r;
        sel_s      = last_r;
        word_s     = {WORD_BITS{1'b0}};

        if (cs_rise_s) begin
            state_s    = ST_IDLE;
            bit_idx_s  = {IDX_W{1'b0}};
            sdata_s    = 1'b0;
            sdata_oe_s = 1'b0;
            if ((state_r == ST_TRAIL) || last_bit_s) begin
                done_s  = 1'b1;
                count_s = count_r + FRAME_COUNT_W'(1);
                ramp_s  = ramp_r + DATA_BITS'(1);
            end else if (state_r == ST_SHIFT) begin
                short_s = 1'b1;
            end else begin
                short_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A coincident sclk fall is absorbed here: only the load happens.
                    if (cs_fall_s) begin
                        if (pattern_mode) begin
                            sel_s = ramp_r;
                        end else if (sample_valid) begin
                            sel_s   = sample_data;
                            ready_s = 1'b1;
                        end else begin
                            sel_s = last_r;
                        end
                        last_s     = sel_s;
                        word_s     = WORD_BITS'(sel_s);
                        shift_s    = word_s << 1'b1;
                        sdata_s    = word_s[WORD_BITS-1];
                        bit_idx_s  = {IDX_W{1'b0}};
                        sdata_oe_s = 1'b1;
                        state_s    = ST_SHIFT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_act_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            state_s = ST_TRAIL;
                            sdata_s = 1'b0;
                        end else begin
                            bit_idx_s = bit_idx_r + IDX_W'(1);
                            sdata_s   = shift_r[WORD_BITS-1];
                            shift_s   = shift_r << 1'b1;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                ST_TRAIL: begin
                    if (sclk_act_s) begin
                        sdata_s = 1'b0;
                    end else begin
                        state_s = ST_TRAIL;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    sdata_s    = 1'b0;
                    sdata_oe_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx_r  <= {IDX_W{1'b0}};
            shift_r    <= {WORD_BITS{1'b0}};
            sdata_r    <= 1'b0;
            sdata_oe_r <= 1'b0;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
            short_r    <= 1'b0;
            count_r    <= {FRAME_COUNT_W{1'b0}};
            ramp_r     <= {DATA_BITS{1'b0}};
            last_r     <= {DATA_BITS{1'b0}};
        end else begin
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            sdata_r    <= sdata_s;
            sdata_oe_r <= sdata_oe_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            short_r    <= short_s;
            count_r    <= count_s;
            ramp_r     <= ramp_s;
            last_r     <= last_s;
        end
    end

    assign sdata        = sdata_r;
    assign sdata_oe     = sdata_oe_r;
    assign sample_ready = ready_r;
    assign frame_done   = done_r;
    assign short_frame  = short_r;
    assign frame_count  = count_r;

endmodule
